lsu_sram_like: RTL

Parametrised load/store unit between the EXE and MEM stages of the five-stage core. It replaces the fixed single-cycle, word-only data-SRAM port with a request/response bus carrying `addr_ok` and `data_ok`. It supports byte, half and word accesses (and dword when `DATA_W=64`), signed or unsigned, with up to `MAX_OUTST` requests in flight. Results return to the pipeline strictly in order, with misalignment (ALE) reporting and a pipeline-flush cancel.

---
 rtl/lsu_pkg.sv | 55 +++++
 rtl/lsu_inflight_fifo.sv | 83 ++++++++
 rtl/lsu_sram_like.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit: operation-code field
// positions, access-size encodings, the in-flight entry layout and the
// byte-enable / load-extension helpers used by lsu_sram_like.
package lsu_pkg;

  // Bit positions inside in_op
  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;

  // Access-size encodings carried in in_op[1:0]
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // One in-flight operation. Data and offset are sized for the widest
  // (64-bit) bus so the same layout serves both bus widths.
  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  offset;
    logic        done;
    logic        drop;
    logic        ale;
    logic [63:0] data;
  } entry_t;

  // Byte enables for an access of the given size starting at byte offset
  function automatic logic [7:0] wstrb_of(input logic [1:0] size,
                                          input logic [2:0] offset);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

  // Truncate a right-aligned value to the access size and sign/zero extend
  function automatic logic [63:0] extend(input logic [63:0] data,
                                         input logic [1:0]  size,
                                         input logic        uns);
    logic [63:0] r;
    case (size)
      SZ_B:    r = uns ? {56'b0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
      SZ_H:    r = uns ? {48'b0, data[15:0]} : {{48{data[15]}}, data[15:0]};
      SZ_W:    r = uns ? {32'b0, data[31:0]} : {{32{data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_inflight_fifo.sv
// lsu_inflight_fifo
// In-order FIFO of accepted load/store operations. Besides push/pop it
// lets the bus completion land in the oldest entry still waiting for data,
// and can mark every stored entry as dropped in one cycle.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_push/i_entry   append an entry at the tail
//   i_pop            remove the head entry
//   i_complete/i_completeData  write data into oldest not-done entry, set done
//   i_dropAll        mark all stored entries as dropped
//   o_head, o_headValid  head entry and whether the FIFO holds anything
//   o_count          current occupancy
module lsu_inflight_fifo import lsu_pkg::*; #(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  entry_t        i_entry,
  input  logic          i_pop,
  input  logic          i_complete,
  input  logic [63:0]   i_completeData,
  input  logic          i_dropAll,
  output entry_t        o_head,
  output logic          o_headValid,
  output logic [CW-1:0] o_count
);

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic          w_found;
  logic [PW-1:0] w_target;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Walk from the head to find the oldest entry still awaiting its
  // data_ok; ALE entries are born done so they are skipped naturally.
  always_comb begin
    w_found  = 1'b0;
    w_target = r_rdPtr;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_found && (i < int'(r_count)) &&
          !r_mem[PW'((int'(r_rdPtr) + i) % DEPTH)].done) begin
        w_found  = 1'b1;
        w_target = PW'((int'(r_rdPtr) + i) % DEPTH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_complete && w_found) begin
        r_mem[w_target].data <= i_completeData;
        r_mem[w_target].done <= 1'b1;
      end
      // Empty slots get marked too; a later push overwrites them anyway
      if (i_dropAll) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i].drop <= 1'b1;
      end
      if (i_push) begin
        r_mem[r_wrPtr] <= i_entry;
        r_wrPtr        <= nextPtr(r_wrPtr);
      end
      if (i_pop) r_rdPtr <= nextPtr(r_rdPtr);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head      = r_mem[r_rdPtr];
  assign o_headValid = (r_count != '0);
  assign o_count     = r_count;

endmodule

// File: rtl/lsu_sram_like.sv
// lsu_sram_like
// Load/store unit between EXE and MEM speaking an addr_ok/data_ok bus.
// Handles byte/half/word(/dword) accesses, misalignment reporting,
// up to MAX_OUTST operations in flight, in-order retirement and flush.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_op/in_addr/in_wdata   operation from EXE
//   flush                      cancel all unretired operations
//   mem_req/mem_wr/mem_size/mem_addr/mem_wstrb/mem_wdata  bus request
//   mem_addr_ok/mem_data_ok/mem_rdata                     bus response
//   out_valid/out_ready/out_rdata/out_ale                 result to MEM
module lsu_sram_like import lsu_pkg::*; #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic                out_ale
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(MAX_OUTST) + 1;

  logic [1:0]        w_size;
  logic              w_ale;
  logic              w_credit;
  logic              w_pop;
  logic              w_accept;
  int                w_lanes;
  logic [DATA_W-1:0] w_wdata;
  logic [63:0]       w_shifted;
  entry_t            w_pushEntry;
  entry_t            w_head;
  logic              w_headValid;
  logic [CW-1:0]     w_count;

  assign w_size = in_op[1:0];

  always_comb begin
    case (w_size)
      SZ_B:    w_ale = 1'b0;
      SZ_H:    w_ale = in_addr[0];
      SZ_W:    w_ale = |in_addr[1:0];
      default: w_ale = |in_addr[2:0];
    endcase
  end

  // A pop this cycle frees its slot immediately for a new acceptance
  assign w_credit = (w_count < CW'(MAX_OUTST)) | w_pop;

  assign in_ready = ~reset & w_credit & ~flush & (w_ale | mem_addr_ok);
  assign mem_req  = ~reset & in_valid & ~w_ale & w_credit & ~flush;
  assign w_accept = in_valid & in_ready;

  // Replicate the low (1<<size) bytes of the store data across every lane
  always_comb begin
    w_lanes = 1 << w_size;
    w_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      w_wdata[i*8 +: 8] = in_wdata[(i % w_lanes)*8 +: 8];
    end
  end

  assign mem_wr    = ~reset & in_op[OP_STORE];
  assign mem_size  = reset ? 2'b00 : w_size;
  assign mem_addr  = reset ? '0 : in_addr;
  assign mem_wdata = reset ? '0 : w_wdata;
  assign mem_wstrb = (reset || !in_op[OP_STORE]) ? '0 :
                     NB'(wstrb_of(w_size, 3'(in_addr[OW-1:0])));

  // ALE entries never see the bus, so they enter the FIFO already done
  always_comb begin
    w_pushEntry        = '0;
    w_pushEntry.op     = in_op;
    w_pushEntry.offset = 3'(in_addr[OW-1:0]);
    w_pushEntry.done   = w_ale;
    w_pushEntry.ale    = w_ale;
  end

  lsu_inflight_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .i_push         (w_accept),
    .i_entry        (w_pushEntry),
    .i_pop          (w_pop),
    .i_complete     (mem_data_ok),
    .i_completeData (64'(mem_rdata)),
    .i_dropAll      (flush),
    .o_head         (w_head),
    .o_headValid    (w_headValid),
    .o_count        (w_count)
  );

  assign out_valid = ~reset & ~flush & w_headValid & w_head.done & ~w_head.drop;

  // Dropped entries that have consumed their data_ok retire silently
  assign w_pop = w_headValid & w_head.done & (w_head.drop | (out_valid & out_ready));

  assign w_shifted = w_head.data >> {w_head.offset, 3'b000};
  assign out_ale   = out_valid & w_head.ale;
  assign out_rdata = (out_valid && !w_head.op[OP_STORE] && !w_head.ale) ?
                     DATA_W'(extend(w_shifted, w_head.op[1:0], w_head.op[OP_UNS])) : '0;

endmodule
